vga_stream_driver: RTL and testbench
====================================

// Module: vga_stream_driver
// PURPOSE
//  Parametrised VGA raster driver. Generates H/V timing with programmable porches and sync polarity,
//  pulls pixels from an upstream frame-buffer reader over a valid/ready stream, and reduces
//  wide input colour to narrow DAC pins with selectable temporal or spatial+temporal dithering.
//  Sits between the frame-buffer RAM controller and the board VGA pins. Flags stream underflow.
// PARAMETERS
//  H_ACTIVE   640  visible pixels/line     | H_FP 16 | H_SYNC 96 | H_BP 48   (pixel clocks)
//  V_ACTIVE   480  visible lines/frame     | V_FP 10 | V_SYNC 2  | V_BP 33   (lines)
//  HSYNC_POL  0    0 = sync pulse drives HSync low, 1 = high; VSYNC_POL likewise
//  IN_R/IN_G/IN_B     5/6/5  input channel widths (PixelData = {R,G,B}, R in MSBs)
//  OUT_R/OUT_G/OUT_B  3/3/2  output pin widths; each OUT_x <= IN_x
//  DITHER_MODE 1   0 = truncate, 1 = temporal, 2 = 2x2 Bayer + temporal
// PORTS
//  PixelClk     in   1       pixel clock
//  Rst          in   1       asynchronous, active-high reset
//  Enable       in   1       0 = hold counters at 0, outputs idle
//  PixelData    in   IN_W    IN_W = IN_R+IN_G+IN_B
//  PixelValid   in   1       upstream has a pixel
//  PixelReady   out  1       driver consumes a pixel this cycle
//  HSync/VSync  out  1       sync pins, polarity per *_POL
//  Red/Green/Blue out OUT_R/OUT_G/OUT_B  colour pins
//  DataEnable   out  1       pins carry a visible pixel
//  FrameStart   out  1       one-cycle pulse with pixel (0,0) on the pins
//  HPos/VPos    out  clog2(H_TOTAL)/clog2(V_TOTAL)  raw counters (stage 0)
//  Underflow    out  1       sticky: visible pixel needed, PixelValid low
//  UnderflowClr in   1       clears Underflow
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; order per line: active, FP, sync, BP. Same for V in lines.
//  - HPos 0..H_TOTAL-1, wraps to 0; VPos increments on the HPos wrap, wraps 0 after V_TOTAL-1.
//  - Sync asserted for HPos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; same for V.
//  - Reset / Enable=0: HPos=VPos=0, syncs at inactive level (~POL), colour 0, DataEnable 0,
//    FrameStart 0, PixelReady 0, frame counter 0; Underflow 0 on reset, held while Enable=0.
//  - PixelReady = Enable && HPos<H_ACTIVE && VPos<V_ACTIVE (combinational from stage 0).
//    Transfer = PixelReady && PixelValid. Timing never stalls.
//  - Pipeline: stage 0 counters; stage 1 registers Sync/DataEnable/FrameStart/colour.
//    Pins lag HPos/VPos by exactly 1 cycle. The pixel transferred at cycle N appears on pins at N+1.
//  - Underflow: PixelReady && !PixelValid -> that pixel is driven 0 and Underflow sets.
//    UnderflowClr clears it; simultaneous set and clear -> set wins.
//  - Blanking (DataEnable=0): colour pins 0.
//  - Dither per channel, D = IN-OUT: D=0 pass-through. Else q = top OUT bits.
//    r = next 2 dropped bits (D=1: {bit,0}). t = threshold 0..3.
//    Output q+1 if r>t && q!=all-ones, else q (saturating).
//  - Threshold: mode 0 -> no increment. Mode 1 -> t = frame[1:0].
//    Mode 2 -> t = (bayer[{VPos[0],HPos[0]}] + frame[1:0]) mod 4, with bayer = {0,2,3,1}.
//  - frame[1:0] increments when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
//  - Enable deasserted mid-frame: counters reset to 0 next edge. Any in-flight stage-1 pixel is discarded.
// STRUCTURE
//  - vga_pkg: DITHER_* mode localparams, BAYER2 table, width-check function
//    (elaboration error if OUT_x > IN_x or DITHER_MODE > 2).
//  - Sub-module vga_dither_channel #(IN_W, OUT_W): combinational q/r/t compare.
//    Instantiated 3x; counters, sync, stream logic and stage 1 live here.
// TESTING  (small timing: H 8/2/2/2, V 4/1/1/1 unless noted)
//  1. Reset then Enable=1, PixelValid=1 -> H_TOTAL=14, V_TOTAL=7.
//     HSync low for HPos 10..11 on pins 1 cycle later. FrameStart every 98 cycles.
//  2. HSYNC_POL=1, VSYNC_POL=1 -> pulses high, otherwise identical to 1.
//     Reset mid-line -> pins idle immediately.
//  3. Drop PixelValid for one visible cycle -> that pixel is 0, Underflow=1 and stays.
//     UnderflowClr in the same cycle as a new underflow -> stays 1.
//  4. DITHER_MODE 1, IN_R=5, OUT_R=3, R input 5'b01110 (q=3, r=2) constant:
//     Red 4,4,3,3 over 4 frames. Input 5'b11111 -> Red always 7 (saturation).
//  5. DITHER_MODE 2, R=5'b01101 (r=1), frame 0: Red 4 at (0,0), 3 at (1,0), (0,1), (1,1).
//  6. Enable low mid-frame for 5 cycles then high -> restart at (0,0), FrameStart 1 cycle later,
//     no PixelReady during low.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg: dither modes, 2x2 Bayer table, configuration check       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_pkg;

  localparam int DITHER_TRUNC    = 0;
  localparam int DITHER_TEMPORAL = 1;
  localparam int DITHER_BAYER    = 2;

  // Index {y[0], x[0]}: entries 0,2,3,1 packed LSB first.
  localparam logic [7:0] BAYER2 = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] bayer2(input logic [1:0] idx);
    return BAYER2[{idx, 1'b0} +: 2];
  endfunction

  function automatic bit cfg_ok(input int in_r, input int in_g, input int in_b,
                                input int out_r, input int out_g, input int out_b,
                                input int mode);
    return (out_r <= in_r) && (out_g <= in_g) && (out_b <= in_b) &&
           (out_r > 0) && (out_g > 0) && (out_b > 0) && (mode >= 0) && (mode <= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_dither_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_dither_channel: one colour channel, IN_W -> OUT_W reduction   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_dither_channel #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  chan_i,
  input  logic [1:0]       thresh_i,
  input  logic             dither_en_i,
  output logic [OUT_W-1:0] chan_o
);

  localparam int DROP = IN_W - OUT_W;

  if (DROP == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{thresh_i, dither_en_i};
    assign chan_o     = chan_i;
  end else begin : g_reduce
    logic [OUT_W-1:0] q;
    logic [1:0]       r;

    assign q = chan_i[IN_W-1 -: OUT_W];

    // r is the two most significant dropped bits; a single dropped bit is padded with 0.
    if (DROP == 1) begin : g_r1
      assign r = {chan_i[0], 1'b0};
    end else begin : g_r2
      assign r = chan_i[DROP-1 -: 2];
      if (DROP > 2) begin : g_low
        logic unused_low;
        assign unused_low = ^chan_i[DROP-3:0];
      end
    end

    assign chan_o = (dither_en_i && (r > thresh_i) && (q != '1)) ? q + 1'b1 : q;
  end

endmodule
`default_nettype wire

// File: rtl/vga_stream_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_stream_driver: VGA timing, pixel stream intake and dithering  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_stream_driver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int IN_R        = 5,
  parameter int IN_G        = 6,
  parameter int IN_B        = 5,
  parameter int OUT_R       = 3,
  parameter int OUT_G       = 3,
  parameter int OUT_B       = 2,
  parameter int DITHER_MODE = 1,
  localparam int IN_W       = IN_R + IN_G + IN_B,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HPOS_W     = $clog2(H_TOTAL),
  localparam int VPOS_W     = $clog2(V_TOTAL)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [IN_W-1:0]   pixel_data_i,
  input  logic              pixel_valid_i,
  output logic              pixel_ready_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [OUT_R-1:0]  red_o,
  output logic [OUT_G-1:0]  green_o,
  output logic [OUT_B-1:0]  blue_o,
  output logic              data_enable_o,
  output logic              frame_start_o,
  output logic [HPOS_W-1:0] hpos_o,
  output logic [VPOS_W-1:0] vpos_o,
  output logic              underflow_o,
  input  logic              underflow_clr_i
);

  if (!cfg_ok(IN_R, IN_G, IN_B, OUT_R, OUT_G, OUT_B, DITHER_MODE)) begin : g_cfg_err
    $error("vga_stream_driver: OUT_x must not exceed IN_x and DITHER_MODE must be 0..2");
  end

  localparam int  HS_FIRST  = H_ACTIVE + H_FP;
  localparam int  HS_LAST   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int  VS_FIRST  = V_ACTIVE + V_FP;
  localparam int  VS_LAST   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam bit  DITHER_ON = (DITHER_MODE != DITHER_TRUNC);

  logic [HPOS_W-1:0] hpos_q, hpos_d;
  logic [VPOS_W-1:0] vpos_q, vpos_d;
  logic [1:0]        frame_q, frame_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              de_q, de_d, fs_q, fs_d, underflow_q, underflow_d;
  logic [OUT_R-1:0]  red_q, red_d;
  logic [OUT_G-1:0]  green_q, green_d;
  logic [OUT_B-1:0]  blue_q, blue_d;

  logic              h_last, v_last, visible, hsync_act, vsync_act;
  logic [1:0]        thresh;
  logic [OUT_R-1:0]  red_dith;
  logic [OUT_G-1:0]  green_dith;
  logic [OUT_B-1:0]  blue_dith;

  assign h_last    = (hpos_q == HPOS_W'(H_TOTAL - 1));
  assign v_last    = (vpos_q == VPOS_W'(V_TOTAL - 1));
  assign visible   = (hpos_q < HPOS_W'(H_ACTIVE)) && (vpos_q < VPOS_W'(V_ACTIVE));
  assign hsync_act = (hpos_q >= HPOS_W'(HS_FIRST)) && (hpos_q <= HPOS_W'(HS_LAST));
  assign vsync_act = (vpos_q >= VPOS_W'(VS_FIRST)) && (vpos_q <= VPOS_W'(VS_LAST));

  assign pixel_ready_o = enable_i && visible;

  always_comb begin
    thresh = frame_q;
    if (DITHER_MODE == DITHER_BAYER) begin
      thresh = bayer2({vpos_q[0], hpos_q[0]}) + frame_q;
    end
  end

  vga_dither_channel #(.IN_W(IN_R), .OUT_W(OUT_R)) u_dither_r (
    .chan_i(pixel_data_i[IN_W-1 -: IN_R]), .thresh_i(thresh),
    .dither_en_i(DITHER_ON), .chan_o(red_dith));
  vga_dither_channel #(.IN_W(IN_G), .OUT_W(OUT_G)) u_dither_g (
    .chan_i(pixel_data_i[IN_G+IN_B-1 -: IN_G]), .thresh_i(thresh),
    .dither_en_i(DITHER_ON), .chan_o(green_dith));
  vga_dither_channel #(.IN_W(IN_B), .OUT_W(OUT_B)) u_dither_b (
    .chan_i(pixel_data_i[IN_B-1:0]), .thresh_i(thresh),
    .dither_en_i(DITHER_ON), .chan_o(blue_dith));

  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (!enable_i) begin
      hpos_d  = '0;
      vpos_d  = '0;
      frame_d = '0;
    end else if (h_last) begin
      hpos_d = '0;
      if (v_last) begin
        vpos_d  = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        vpos_d = vpos_q + VPOS_W'(1);
      end
    end else begin
      hpos_d = hpos_q + HPOS_W'(1);
    end
  end

  // Stage 1: a disabled cycle drives idle pins, discarding whatever was in flight.
  always_comb begin
    hsync_d     = ~HSYNC_POL;
    vsync_d     = ~VSYNC_POL;
    de_d        = 1'b0;
    fs_d        = 1'b0;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    underflow_d = underflow_q;
    if (enable_i) begin
      hsync_d = hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = vsync_act ? VSYNC_POL : ~VSYNC_POL;
      de_d    = visible;
      fs_d    = (hpos_q == '0) && (vpos_q == '0);
      if (visible && pixel_valid_i) begin
        red_d   = red_dith;
        green_d = green_dith;
        blue_d  = blue_dith;
      end
      if (underflow_clr_i) underflow_d = 1'b0;
      if (visible && !pixel_valid_i) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      frame_q     <= '0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      frame_q     <= frame_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign data_enable_o = de_q;
  assign frame_start_o = fs_q;
  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign underflow_o   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_stream_driver: three drivers (temporal / Bayer+inverted    |
// | sync / truncate) on a 14x7 raster against a frame-position model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_vga_stream_driver;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int ND = 3;

  int  MODE [ND] = '{1, 2, 0};
  bit  POL  [ND] = '{1'b0, 1'b1, 1'b0};
  int  BAYER[4]  = '{0, 2, 3, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] pix = '0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;

  logic       ready [ND];
  logic       hs [ND];
  logic       vs [ND];
  logic [2:0] red [ND];
  logic [2:0] green [ND];
  logic [1:0] blue [ND];
  logic       de [ND];
  logic       fs [ND];
  logic [3:0] hpos [ND];
  logic [2:0] vpos [ND];
  logic       uf [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vga_stream_driver #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(g == 1), .VSYNC_POL(g == 1),
      .DITHER_MODE((g == 0) ? 1 : ((g == 1) ? 2 : 0))
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en),
      .pixel_data_i(pix), .pixel_valid_i(valid), .pixel_ready_o(ready[g]),
      .hsync_o(hs[g]), .vsync_o(vs[g]),
      .red_o(red[g]), .green_o(green[g]), .blue_o(blue[g]),
      .data_enable_o(de[g]), .frame_start_o(fs[g]),
      .hpos_o(hpos[g]), .vpos_o(vpos[g]),
      .underflow_o(uf[g]), .underflow_clr_i(clr)
    );
  end

  int n_pass = 0;
  int n_total = 0;
  int n = 0;     // cycles since the raster last restarted at (0,0)
  bit m_uf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int dith(input int val, input int inw, input int outw,
                              input int mode, input int t);
    int d, q, r, qmax;
    d = inw - outw;
    if (d == 0) return val;
    q    = val >> d;
    r    = ((val << 2) >> d) & 3;
    qmax = (1 << outw) - 1;
    if (mode != 0 && r > t && q < qmax) return q + 1;
    return q;
  endfunction

  // One pixel clock: check stage-0 outputs, advance, check pins against the model.
  task automatic run_cycle();
    int h, v, fr, t;
    bit rdy, hsa, vsa, efs, nuf;
    int er[ND], eg[ND], eb[ND];
    h   = n % HT;
    v   = (n / HT) % VT;
    fr  = (n / FT) % 4;
    rdy = en && (h < 8) && (v < 4);
    hsa = en && (h >= 10) && (h <= 11);
    vsa = en && (v == 5);
    efs = en && (h == 0) && (v == 0);
    for (int d = 0; d < ND; d++) begin
      t = (MODE[d] == 2) ? (BAYER[(v % 2) * 2 + (h % 2)] + fr) % 4 : fr;
      er[d] = 0; eg[d] = 0; eb[d] = 0;
      if (rdy && valid) begin
        er[d] = dith(int'(pix[15:11]), 5, 3, MODE[d], t);
        eg[d] = dith(int'(pix[10:5]), 6, 3, MODE[d], t);
        eb[d] = dith(int'(pix[4:0]), 5, 2, MODE[d], t);
      end
    end
    nuf = m_uf;
    if (en && clr) nuf = 1'b0;
    if (rdy && !valid) nuf = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("ready[%0d]", d), int'(ready[d]), int'(rdy));
      chk($sformatf("hpos[%0d]", d), int'(hpos[d]), h);
      chk($sformatf("vpos[%0d]", d), int'(vpos[d]), v);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("hsync[%0d]", d), int'(hs[d]), int'(hsa ? POL[d] : !POL[d]));
      chk($sformatf("vsync[%0d]", d), int'(vs[d]), int'(vsa ? POL[d] : !POL[d]));
      chk($sformatf("de[%0d]", d), int'(de[d]), int'(rdy));
      chk($sformatf("fstart[%0d]", d), int'(fs[d]), int'(efs));
      chk($sformatf("red[%0d]", d), int'(red[d]), er[d]);
      chk($sformatf("green[%0d]", d), int'(green[d]), eg[d]);
      chk($sformatf("blue[%0d]", d), int'(blue[d]), eb[d]);
      chk($sformatf("underflow[%0d]", d), int'(uf[d]), int'(nuf));
    end
    m_uf = nuf;
    n = en ? n + 1 : 0;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s hsync[%0d]", tag, d), int'(hs[d]), int'(!POL[d]));
      chk($sformatf("%s vsync[%0d]", tag, d), int'(vs[d]), int'(!POL[d]));
      chk($sformatf("%s de[%0d]", tag, d), int'(de[d]), 0);
      chk($sformatf("%s fstart[%0d]", tag, d), int'(fs[d]), 0);
      chk($sformatf("%s rgb[%0d]", tag, d), int'({red[d], green[d], blue[d]}), 0);
      chk($sformatf("%s underflow[%0d]", tag, d), int'(uf[d]), 0);
      chk($sformatf("%s hpos[%0d]", tag, d), int'(hpos[d]), 0);
      chk($sformatf("%s vpos[%0d]", tag, d), int'(vpos[d]), 0);
      if (!en) chk($sformatf("%s ready[%0d]", tag, d), int'(ready[d]), 0);
    end
  endtask

  // Asynchronous reset asserted mid-cycle: pins must go idle before any clock edge.
  task automatic mid_reset(input string tag);
    rst = 1'b1;
    #2;
    check_idle(tag);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    n    = 0;
    m_uf = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pix;
    int          fr;
    int          h;
    int          v;
    int          e0;   // temporal
    int          e1;   // Bayer + temporal
    int          e2;   // truncate
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int r, input int fr, input int h, input int v,
                              input int e0, input int e1, input int e2);
    vec_t x;
    x.pix = 16'(r << 11);
    x.fr = fr; x.h = h; x.v = v;
    x.e0 = e0; x.e1 = e1; x.e2 = e2;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(13, 0, 0, 0, 4, 4, 3);
    tbl[1]  = mk(13, 0, 1, 0, 4, 3, 3);
    tbl[2]  = mk(31, 0, 2, 0, 7, 7, 7);
    tbl[3]  = mk(14, 0, 4, 0, 4, 4, 3);
    tbl[4]  = mk(13, 0, 0, 1, 4, 3, 3);
    tbl[5]  = mk(13, 0, 1, 1, 4, 3, 3);
    tbl[6]  = mk(31, 1, 2, 0, 7, 7, 7);
    tbl[7]  = mk(14, 1, 4, 0, 4, 4, 3);
    tbl[8]  = mk(13, 1, 0, 1, 3, 4, 3);
    tbl[9]  = mk(13, 1, 1, 1, 3, 3, 3);
    tbl[10] = mk(13, 2, 0, 0, 3, 3, 3);
    tbl[11] = mk(31, 2, 2, 0, 7, 7, 7);
    tbl[12] = mk(14, 2, 4, 0, 3, 3, 3);
    tbl[13] = mk(31, 3, 2, 0, 7, 7, 7);
    tbl[14] = mk(14, 3, 4, 0, 3, 3, 3);
    tbl[15] = mk(13, 3, 0, 1, 3, 3, 3);
    tbl[16] = mk(13, 3, 1, 1, 3, 4, 3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    n = 0;
    m_uf = 1'b0;

    // Randomised raster with occasional stalls, clears and enable drops
    for (int i = 0; i < 260; i++) begin
      en    = ($urandom_range(0, 39) != 0);
      pix   = 16'($urandom);
      valid = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      run_cycle();
    end

    // Reset mid-line, then underflow corner cases from pixel (0,0)
    en = 1'b1; valid = 1'b1; clr = 1'b0;
    repeat (5) run_cycle();
    mid_reset("midline");
    valid = 1'b0; clr = 1'b0; pix = 16'hFFFF;
    run_cycle();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("uf_set[%0d]", d), int'(uf[d]), 1);
      chk($sformatf("uf_pixel_zero[%0d]", d), int'({red[d], green[d], blue[d]}), 0);
      chk($sformatf("uf_de[%0d]", d), int'(de[d]), 1);
    end
    valid = 1'b1;
    run_cycle();
    for (int d = 0; d < ND; d++) chk($sformatf("uf_sticky[%0d]", d), int'(uf[d]), 1);
    clr = 1'b1;
    run_cycle();
    for (int d = 0; d < ND; d++) chk($sformatf("uf_cleared[%0d]", d), int'(uf[d]), 0);
    valid = 1'b0;
    run_cycle();
    for (int d = 0; d < ND; d++) chk($sformatf("uf_set_beats_clr[%0d]", d), int'(uf[d]), 1);
    clr = 1'b0; valid = 1'b1;

    // Enable low mid-frame for 5 cycles, then restart at (0,0)
    repeat (30) begin
      pix = 16'($urandom);
      run_cycle();
    end
    en = 1'b0;
    repeat (5) begin
      run_cycle();
      for (int d = 0; d < ND; d++) chk($sformatf("en_low_ready[%0d]", d), int'(ready[d]), 0);
    end
    en = 1'b1;
    run_cycle();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("restart_fstart[%0d]", d), int'(fs[d]), 1);
      chk($sformatf("restart_hpos[%0d]", d), int'(hpos[d]), 1);
    end

    // Dither vectors at fixed frame/position, four frames from a fresh reset
    mid_reset("pre_table");
    for (int i = 0; i < 17; i++) begin
      int tgt, guard;
      tgt   = tbl[i].fr * FT + tbl[i].v * HT + tbl[i].h;
      guard = 0;
      while (n < tgt && guard < 400) begin
        pix = 16'($urandom); valid = 1'b1; clr = 1'b0;
        run_cycle();
        guard++;
      end
      chk($sformatf("tbl%0d hpos", i), int'(hpos[0]), tbl[i].h);
      chk($sformatf("tbl%0d vpos", i), int'(vpos[0]), tbl[i].v);
      pix = tbl[i].pix; valid = 1'b1;
      run_cycle();
      chk($sformatf("tbl%0d red temporal", i), int'(red[0]), tbl[i].e0);
      chk($sformatf("tbl%0d red bayer", i), int'(red[1]), tbl[i].e1);
      chk($sformatf("tbl%0d red truncate", i), int'(red[2]), tbl[i].e2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
